// File: rtl/execute_divide_multi_pkg.sv
// Shared definitions for the multi-bit restoring divider.
//   div_state_e : FSM state encoding (IDLE / CALC / DONE)
//   div_iter    : cycles spent in CALC, ceil((W+1)/BPC)
//   div_qw      : internal quotient width, ITER*BPC
//   div_dw      : internal dividend/divisor width, W+QW-1
// The execute stage uses div_iter to size its stall counters.
package execute_divide_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic int div_iter(input int w, input int bpc);
    return (w + bpc) / bpc;
  endfunction

  function automatic int div_qw(input int w, input int bpc);
    return div_iter(w, bpc) * bpc;
  endfunction

  function automatic int div_dw(input int w, input int bpc);
    return w + div_qw(w, bpc) - 1;
  endfunction

endpackage

// File: rtl/execute_divide_step.sv
// One combinational restoring-division step over DW bits.
//   i_dividend : partial remainder
//   i_divisor  : aligned divisor
//   o_dividend : next partial remainder (restored when the subtract underflows)
//   o_qbit     : quotient bit produced by this step
module execute_divide_step
  import execute_divide_multi_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [DW-1:0] i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic [DW-1:0] o_dividend,
  output logic          o_qbit
);

  logic [DW:0] w_diff;

  // One extra bit so the borrow out doubles as the sign of the difference.
  assign w_diff     = {1'b0, i_dividend} - {1'b0, i_divisor};
  assign o_qbit     = ~w_diff[DW];
  assign o_dividend = o_qbit ? w_diff[DW-1:0] : i_dividend;

endmodule

// File: rtl/execute_divide_multi.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, signed or
// unsigned, BPC quotient bits per clock.
//   clk, rst_n    : clock, asynchronous active-low reset
//   abort         : synchronous flush, beats start
//   start         : request, sampled only in IDLE
//   is_signed     : 1 = signed divide
//   numer, denom  : dividend (2W), divisor (W)
//   busy, done    : busy in CALC/DONE; done is a one-cycle result strobe
//   exc_zero      : divisor was zero
//   exc_overflow  : quotient does not fit in W bits
//   quotient      : quotient (sign applied)
//   remainder     : remainder, sign of the dividend
module execute_divide_multi
  import execute_divide_multi_pkg::*;
#(
  parameter int W   = 32,
  parameter int BPC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           abort,
  input  logic           start,
  input  logic           is_signed,
  input  logic [2*W-1:0] numer,
  input  logic [W-1:0]   denom,
  output logic           busy,
  output logic           done,
  output logic           exc_zero,
  output logic           exc_overflow,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder
);

  localparam int ITER = div_iter(W, BPC);
  localparam int QW   = div_qw(W, BPC);
  localparam int DW   = div_dw(W, BPC);
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [QW-1:0] HALF = {{(QW-1){1'b0}}, 1'b1} << (W - 1);

  div_state_e r_state, w_next_state;

  logic [CW-1:0]  r_cnt;
  logic [DW-1:0]  r_dividend;
  logic [DW-1:0]  r_divisor;
  logic [QW-1:0]  r_q;
  logic           r_signed;
  logic           r_qneg;
  logic           r_rneg;
  logic           r_exc_zero;
  logic           r_exc_ovf;

  logic           w_accept;
  logic           w_numer_neg;
  logic           w_denom_neg;
  logic [2*W-1:0] w_numer_abs;
  logic [W-1:0]   w_denom_abs;
  logic [DW-1:0]  w_dvd [BPC+1];
  logic [DW-1:0]  w_dvs [BPC+1];
  logic [BPC-1:0] w_qbits;
  logic [QW-1:0]  w_q_next;
  logic           w_ovf;

  // Operand magnitudes; the 2W-bit unsigned magnitude holds 2^(2W-1).
  assign w_numer_neg = is_signed & numer[2*W-1];
  assign w_denom_neg = is_signed & denom[W-1];
  assign w_numer_abs = w_numer_neg ? -numer : numer;
  assign w_denom_abs = w_denom_neg ? -denom : denom;

  // BPC steps chained in one cycle; step 0 yields the most significant bit.
  assign w_dvd[0] = r_dividend;
  assign w_dvs[0] = r_divisor;

  for (genvar gi = 0; gi < BPC; gi++) begin : g_step
    execute_divide_step #(.DW(DW)) u_step (
      .i_dividend (w_dvd[gi]),
      .i_divisor  (w_dvs[gi]),
      .o_dividend (w_dvd[gi+1]),
      .o_qbit     (w_qbits[BPC-1-gi])
    );
    assign w_dvs[gi+1] = w_dvs[gi] >> 1;
  end

  assign w_q_next = {r_q[QW-BPC-1:0], w_qbits};

  // Quotients of 2^QW or more saturate to all ones, so the upper-bit test
  // still flags them.
  always_comb begin
    w_ovf = 1'b0;
    if (!r_signed)
      w_ovf = |w_q_next[QW-1:W];
    else if (r_qneg)
      w_ovf = (w_q_next > HALF);
    else
      w_ovf = (w_q_next >= HALF);
  end

  assign w_accept = (r_state == ST_IDLE) && start && !abort;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = (denom == '0) ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == CW'(1)) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (abort) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_q        <= '0;
      r_signed   <= 1'b0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_exc_zero <= 1'b0;
      r_exc_ovf  <= 1'b0;
    end else if (!abort) begin
      if (w_accept) begin
        r_cnt      <= CW'(ITER);
        r_dividend <= DW'(w_numer_abs);
        r_divisor  <= {w_denom_abs, {(QW-1){1'b0}}};
        r_q        <= '0;
        r_signed   <= is_signed;
        r_qneg     <= w_numer_neg ^ w_denom_neg;
        r_rneg     <= w_numer_neg;
        r_exc_zero <= (denom == '0);
        r_exc_ovf  <= 1'b0;
      end else if (r_state == ST_CALC) begin
        r_cnt      <= r_cnt - CW'(1);
        r_dividend <= w_dvd[BPC];
        r_divisor  <= w_dvs[BPC];
        r_q        <= w_q_next;
        if (r_cnt == CW'(1)) r_exc_ovf <= w_ovf;
      end
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign exc_zero     = r_exc_zero;
  assign exc_overflow = r_exc_ovf;
  assign quotient     = r_qneg ? -r_q[W-1:0] : r_q[W-1:0];
  assign remainder    = r_rneg ? -r_dividend[W-1:0] : r_dividend[W-1:0];

endmodule

// File: tb/tb_execute_divide_multi.sv
module tb_execute_divide_multi;

  localparam int W     = 32;
  localparam int ITER1 = (W + 1 + 1 - 1) / 1;
  localparam int ITER2 = (W + 1 + 2 - 1) / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        abort = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [63:0] numer = '0;
  logic [31:0] denom = '0;

  logic        busy1, done1, ez1, eo1;
  logic [31:0] q1, r1;
  logic        busy2, done2, ez2, eo2;
  logic [31:0] q2, r2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  execute_divide_multi #(.W(32), .BPC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .start(start), .is_signed(is_signed),
    .numer(numer), .denom(denom), .busy(busy1), .done(done1), .exc_zero(ez1),
    .exc_overflow(eo1), .quotient(q1), .remainder(r1)
  );

  execute_divide_multi #(.W(32), .BPC(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .start(start), .is_signed(is_signed),
    .numer(numer), .denom(denom), .busy(busy2), .done(done2), .exc_zero(ez2),
    .exc_overflow(eo2), .quotient(q2), .remainder(r2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit division on magnitudes, signs applied afterwards.
  function automatic void model(input logic sgn, input logic [63:0] n, input logic [31:0] d,
                                output logic ez, output logic eo,
                                output logic [31:0] q, output logic [31:0] r);
    logic        nneg, dneg;
    logic [63:0] mn, md, qm, rm;
    ez = 1'b0; eo = 1'b0; q = '0; r = '0;
    if (d == 32'd0) begin
      ez = 1'b1;
      return;
    end
    nneg = sgn && n[63];
    dneg = sgn && d[31];
    mn = nneg ? (~n + 64'd1) : n;
    md = dneg ? {32'd0, (~d + 32'd1)} : {32'd0, d};
    qm = mn / md;
    rm = mn % md;
    if (!sgn)             eo = (qm >= 64'h1_0000_0000);
    else if (nneg ^ dneg) eo = (qm >  64'h8000_0000);
    else                  eo = (qm >= 64'h8000_0000);
    q = (nneg ^ dneg) ? (~qm[31:0] + 32'd1) : qm[31:0];
    r = nneg ? (~rm[31:0] + 32'd1) : rm[31:0];
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy1"}, busy1, 0); chk({tag, "_done1"}, done1, 0);
    chk({tag, "_ez1"}, ez1, 0);     chk({tag, "_eo1"}, eo1, 0);
    chk({tag, "_q1"}, q1, 0);       chk({tag, "_r1"}, r1, 0);
    chk({tag, "_busy2"}, busy2, 0); chk({tag, "_done2"}, done2, 0);
    chk({tag, "_ez2"}, ez2, 0);     chk({tag, "_eo2"}, eo2, 0);
    chk({tag, "_q2"}, q2, 0);       chk({tag, "_r2"}, r2, 0);
  endtask

  // Runs one operation on both instances; glitch>0 pulses a junk start in that CALC cycle.
  task automatic run_op(input logic sgn, input logic [63:0] n, input logic [31:0] d, input int glitch);
    logic        ez, eo;
    logic [31:0] q, r;
    int          last;
    model(sgn, n, d, ez, eo, q, r);
    @(posedge clk); #1;
    is_signed = sgn; numer = n; denom = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; numer = {$urandom, $urandom}; denom = $urandom; is_signed = $urandom_range(0, 1);
    last = ez ? 2 : ITER1 + 1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      chk("done1", done1, ez ? (c == 1) : (c == ITER1 + 1));
      chk("busy1", busy1, ez ? (c == 1) : (c <= ITER1 + 1));
      chk("done2", done2, ez ? (c == 1) : (c == ITER2 + 1));
      chk("busy2", busy2, ez ? (c == 1) : (c <= ITER2 + 1));
      if (c == 1 && !ez) begin
        chk("clr_ez1", ez1, 0); chk("clr_eo1", eo1, 0);
        chk("clr_ez2", ez2, 0); chk("clr_eo2", eo2, 0);
      end
      if ((ez && c == 1) || (!ez && c == ITER1 + 1)) begin
        chk("ez1", ez1, ez); chk("eo1", eo1, eo);
        if (!ez && !eo) begin chk("q1", q1, q); chk("r1", r1, r); end
      end
      if ((ez && c == 1) || (!ez && c >= ITER2 + 1)) begin
        chk("ez2", ez2, ez); chk("eo2", eo2, eo);
        if (!ez && !eo) begin chk("q2", q2, q); chk("r2", r2, r); end
      end
      if (c == glitch) begin
        start = 1'b1; numer = 64'd999; denom = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_idle_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(1'b0, 64'd100, 32'd7, 0);
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 32'd2, 0);
    run_op(1'b1, 64'd1234, 32'd0, 0);
    run_op(1'b0, 64'hDEAD_BEEF, 32'd0, 0);
    run_op(1'b0, 64'd100, 32'd7, 0);
    run_op(1'b0, 64'h1_0000_0000, 32'd1, 0);
    run_op(1'b1, 64'hFFFF_FFFF_8000_0000, 32'd1, 0);
    run_op(1'b1, 64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 64'd100, 32'd7, 3);

    // Abort in cycle T+5
    @(posedge clk); #1;
    is_signed = 1'b0; numer = 64'd100; denom = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("abort_busy1", busy1, 1); chk("abort_busy2", busy2, 1);
      if (c == 5) abort = 1'b1;
    end
    @(posedge clk); #1;
    abort = 1'b0;
    for (int c = 6; c <= 40; c++) begin
      @(negedge clk);
      chk("abort_idle_busy1", busy1, 0); chk("abort_idle_done1", done1, 0);
      chk("abort_idle_busy2", busy2, 0); chk("abort_idle_done2", done2, 0);
    end

    // abort and start together in IDLE
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; numer = 64'd100; denom = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("abst_busy1", busy1, 0); chk("abst_done1", done1, 0);
      chk("abst_busy2", busy2, 0); chk("abst_done2", done2, 0);
    end

    // Asynchronous reset mid-CALC
    @(posedge clk); #1;
    is_signed = 1'b0; numer = 64'd100; denom = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 chk("pre_rst_busy1", busy1, 1);
    rst_n = 1'b0;
    #1 check_idle_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 64'd100, 32'd7, 0);

    // Randomised operations
    for (int i = 0; i < 24; i++) begin
      logic [63:0] n;
      logic [31:0] d;
      logic        s;
      n = {$urandom, $urandom};
      n = n >> $urandom_range(0, 63);
      d = $urandom;
      d = d >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) d = '0;
      s = $urandom_range(0, 1);
      run_op(s, n, d, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
